// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the fetch path: word size, canonical NOP,
// reset vector and the entry type carried through the instruction buffer.
package riscv_pkg;

  localparam int unsigned     XLEN         = 32;
  localparam logic [31:0]     NOP_INSTR    = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

  // One buffered fetch: the instruction word and the PC it was fetched from
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Force a byte address onto a word boundary
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries. Flush wins over a same-cycle push.
// The head entry is presented combinationally from the storage registers.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  fetch_entry_t                 i_entry,
  input  logic                         i_pop,
  input  logic                         i_flush,
  output fetch_entry_t                 o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (32'(r_count) == DEPTH);
  assign o_head  = r_mem[r_rd_ptr];

  assign w_do_pop  = i_pop && !i_flush && !o_empty;
  assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);

  // Pointer and occupancy bookkeeping; flush empties the buffer in one edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  // Entry storage needs no reset: occupancy decides what is valid
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_entry;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word fetches over a
// req/gnt/rvalid handshake, buffers returned words and presents them to
// decode, injecting a NOP whenever nothing valid is available.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC        = RESET_VECTOR,
  parameter int unsigned     FIFO_DEPTH      = 2,
  parameter int unsigned     MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            PCsrc,
  input  logic [XLEN-1:0] br_target,
  input  logic            trap_take,
  input  logic [XLEN-1:0] trap_pc,
  output logic [XLEN-1:0] InstF,
  output logic [XLEN-1:0] PCF,
  output logic            instf_valid
);

  localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING+1);
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH+1);

  // r_outstanding counts every request in flight, stale or not;
  // r_drop is the subset of those whose responses must be discarded.
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_rsp_pc;
  logic [XLEN-1:0]  r_last_pc;
  logic [CNT_W-1:0] r_outstanding;
  logic [CNT_W-1:0] r_drop;
  logic             r_run;

  logic              w_redirect;
  logic [XLEN-1:0]   w_target;
  logic              w_hs;
  logic [CNT_W-1:0]  w_live_out;
  logic              w_live_rsp;
  logic              w_bypass;
  logic              w_fifo_push;
  logic              w_fifo_pop;
  fetch_entry_t      w_push_entry;
  fetch_entry_t      w_head;
  logic [FCNT_W-1:0] w_fifo_count;
  logic              w_fifo_full;
  logic              w_fifo_empty;

  assign w_redirect = trap_take | PCsrc;
  assign w_target   = align_word(trap_take ? trap_pc : br_target);

  // Only live (non-dropped) requests will occupy buffer space on return
  assign w_live_out = r_outstanding - r_drop;

  assign imem_req  = r_run && !w_redirect
                  && (32'(r_outstanding) < MAX_OUTSTANDING)
                  && ((32'(w_fifo_count) + 32'(w_live_out)) < FIFO_DEPTH);
  assign imem_addr = r_pc;
  assign w_hs      = imem_req && imem_gnt;

  // A response is kept only if no stale words remain ahead of it and no
  // redirect is flushing the path in the same cycle
  assign w_live_rsp   = imem_rvalid && (r_drop == '0) && !w_redirect;
  assign w_bypass     = w_fifo_empty && w_live_rsp;
  assign w_fifo_push  = w_live_rsp && !(w_bypass && !stall);
  assign w_fifo_pop   = !w_fifo_empty && !stall && !w_redirect;
  assign w_push_entry = '{pc: r_rsp_pc, instr: imem_rdata};

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_fifo_push),
    .i_entry(w_push_entry),
    .i_pop  (w_fifo_pop),
    .i_flush(w_redirect),
    .o_head (w_head),
    .o_count(w_fifo_count),
    .o_full (w_fifo_full),
    .o_empty(w_fifo_empty)
  );

  // Decode-facing view: buffered head first, else a word arriving into an
  // empty buffer passes straight through, else a NOP with the last PC held
  always_comb begin
    InstF       = NOP_INSTR;
    PCF         = r_last_pc;
    instf_valid = 1'b0;
    if (!w_fifo_empty) begin
      InstF       = w_head.instr;
      PCF         = w_head.pc;
      instf_valid = 1'b1;
    end else if (w_bypass) begin
      InstF       = imem_rdata;
      PCF         = r_rsp_pc;
      instf_valid = 1'b1;
    end
  end

  // PC, response-PC and request counters; a redirect turns everything still
  // in flight after this edge into stale responses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= align_word(RESET_PC);
      r_rsp_pc      <= align_word(RESET_PC);
      r_last_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_run         <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_redirect) begin
        r_pc     <= w_target;
        r_rsp_pc <= w_target;
        r_drop   <= r_outstanding - CNT_W'(imem_rvalid);
      end else begin
        if (w_hs)       r_pc     <= r_pc + XLEN'(4);
        if (w_live_rsp) r_rsp_pc <= r_rsp_pc + XLEN'(4);
        if (imem_rvalid && (r_drop != '0)) r_drop <= r_drop - CNT_W'(1);
      end
      r_outstanding <= r_outstanding + CNT_W'(w_hs) - CNT_W'(imem_rvalid);
      if (instf_valid) r_last_pc <= PCF;
    end
  end

  // Protocol sanity: no response without a request, no buffer overflow
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!imem_rvalid || (r_outstanding != '0));
      assert (!(w_fifo_push && w_fifo_full && !w_fifo_pop));
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle table from reset through stall,
// redirects, misaligned target and PC wrap, then hand-written redirect and
// backpressure sequences, all against a small in-order imem model.
module tb_fetch_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        PCsrc;
  logic [31:0] br_target;
  logic        trap_take;
  logic [31:0] trap_pc;
  logic [31:0] InstF;
  logic [31:0] PCF;
  logic        instf_valid;

  fetch_unit #(
    .RESET_PC       (32'h0000_0000),
    .FIFO_DEPTH     (2),
    .MAX_OUTSTANDING(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .PCsrc      (PCsrc),
    .br_target  (br_target),
    .trap_take  (trap_take),
    .trap_pc    (trap_pc),
    .InstF      (InstF),
    .PCF        (PCF),
    .instf_valid(instf_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned ready;
    bit          stale;
  } req_t;

  typedef struct {
    bit          stall;
    bit          pcsrc;
    logic [31:0] bt;
    bit          trap;
    logic [31:0] tp;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pcf;
  } vec_t;

  localparam int NV = 29;
  vec_t tbl [NV];

  req_t        q[$];
  int unsigned cyc;
  int unsigned rsp_lat;
  bit          rsp_en;
  int          checks;
  int          failures;
  int          consumed;
  int          stale_seen;
  logic [31:0] exp_pc;
  logic [31:0] exp_addr;
  logic [31:0] last_cons_pc;
  logic        s_req;
  logic [31:0] s_addr;
  logic        s_valid;
  logic [31:0] s_pcf;
  logic [31:0] s_inst;

  // Memory contents: R-type opcode in the low bits so no word equals the NOP
  function automatic logic [31:0] memword(input logic [31:0] a);
    return {a[26:2], 7'h33};
  endfunction

  function automatic vec_t v(input bit st, input bit pc, input logic [31:0] bt,
                             input bit tr, input logic [31:0] tp, input bit er,
                             input logic [31:0] ea, input bit ev, input logic [31:0] ep);
    vec_t r;
    r.stall = st; r.pcsrc = pc; r.bt = bt; r.trap = tr; r.tp = tp;
    r.e_req = er; r.e_addr = ea; r.e_valid = ev; r.e_pcf = ep;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stall = 1'b0; PCsrc = 1'b0; br_target = '0; trap_take = 1'b0; trap_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_req",   32'(imem_req), 32'h0);
    check("rst_valid", 32'(instf_valid), 32'h0);
    check("rst_pcf",   PCF, 32'h0);
    check("rst_inst",  InstF, NOP_INSTR);
    rst = 1'b0;
    cyc = 0; exp_pc = '0; exp_addr = '0;
  endtask

  // One clock cycle: drive inputs and imem response, sample, check the
  // in-order stream, update the imem model, then advance to the next negedge
  task automatic step(input bit st, input bit pc_i, input logic [31:0] bt,
                      input bit tr_i, input logic [31:0] tp, input bit gnt_i);
    bit          redir;
    logic [31:0] tgt;
    stall = st; PCsrc = pc_i; br_target = bt; trap_take = tr_i; trap_pc = tp;
    imem_gnt = gnt_i;
    if (rsp_en && (q.size() > 0) && (q[0].ready <= cyc)) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memword(q[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    #1;
    s_req = imem_req; s_addr = imem_addr; s_valid = instf_valid; s_pcf = PCF; s_inst = InstF;
    redir = tr_i | pc_i;
    tgt   = tr_i ? tp : bt;
    tgt[1:0] = 2'b00;
    if (!instf_valid) check("nop_inject", InstF, NOP_INSTR);
    if (imem_rvalid && q[0].stale) begin
      stale_seen++;
      check("stale_drop", 32'(instf_valid), 32'h0);
    end
    if (redir) check("redir_req", 32'(imem_req), 32'h0);
    if (imem_req) check("req_addr", imem_addr, exp_addr);
    if (instf_valid && !st && !redir) begin
      check("stream_pc", PCF, exp_pc);
      check("stream_inst", InstF, memword(exp_pc));
      last_cons_pc = PCF;
      exp_pc = exp_pc + 32'd4;
      consumed++;
    end
    if (imem_rvalid) void'(q.pop_front());
    if (imem_req && imem_gnt) begin
      q.push_back('{exp_addr, cyc + rsp_lat, 1'b0});
      exp_addr = exp_addr + 32'd4;
    end
    if (redir) begin
      foreach (q[k]) q[k].stale = 1'b1;
      exp_pc = tgt; exp_addr = tgt;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Build two outstanding requests, redirect, expect both responses dropped
  task automatic redirect_test(input string nm, input bit pc_i, input logic [31:0] bt,
                               input bit tr_i, input logic [31:0] tp, input logic [31:0] exp_tgt);
    int n;
    int cons0;
    do_reset();
    rsp_lat = 1; rsp_en = 1'b0;
    n = 0;
    while ((q.size() < 2) && (n < 10)) begin
      step(0, 0, 0, 0, 0, 1);
      n++;
    end
    check({nm, "_outstanding"}, 32'(q.size()), 32'd2);
    step(0, pc_i, bt, tr_i, tp, 1);
    rsp_en = 1'b1; stale_seen = 0; cons0 = consumed;
    n = 0;
    while ((consumed == cons0) && (n < 20)) begin
      step(0, 0, 0, 0, 0, 1);
      n++;
    end
    check({nm, "_progress"}, 32'(consumed > cons0), 32'h1);
    check({nm, "_dropped"}, 32'(stale_seen), 32'd2);
    check({nm, "_first_pc"}, last_cons_pc, exp_tgt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cons0;
    checks = 0; failures = 0; consumed = 0; stale_seen = 0; cyc = 0;
    rsp_lat = 1; rsp_en = 1'b1; last_cons_pc = '0;
    rst = 1'b1; stall = 1'b0; PCsrc = 1'b0; br_target = '0; trap_take = 1'b0; trap_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

    // stall pcsrc bt trap tp | req addr valid pcf   (zero-wait imem, 1-cycle response)
    tbl[0]  = v(0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    tbl[1]  = v(0, 0, 0, 0, 0, 1, 32'h0, 0, 32'h0);
    tbl[2]  = v(0, 0, 0, 0, 0, 1, 32'h4, 1, 32'h0);
    tbl[3]  = v(0, 0, 0, 0, 0, 1, 32'h8, 1, 32'h4);
    tbl[4]  = v(1, 0, 0, 0, 0, 1, 32'hC, 1, 32'h8);
    tbl[5]  = v(1, 0, 0, 0, 0, 0, 32'h0, 1, 32'h8);
    tbl[6]  = v(1, 0, 0, 0, 0, 0, 32'h0, 1, 32'h8);
    tbl[7]  = v(1, 0, 0, 0, 0, 0, 32'h0, 1, 32'h8);
    tbl[8]  = v(1, 0, 0, 0, 0, 0, 32'h0, 1, 32'h8);
    tbl[9]  = v(1, 0, 0, 0, 0, 0, 32'h0, 1, 32'h8);
    tbl[10] = v(0, 0, 0, 0, 0, 0, 32'h0, 1, 32'h8);
    tbl[11] = v(0, 0, 0, 0, 0, 1, 32'h10, 1, 32'hC);
    tbl[12] = v(0, 0, 0, 0, 0, 1, 32'h14, 1, 32'h10);
    tbl[13] = v(0, 0, 0, 0, 0, 1, 32'h18, 1, 32'h14);
    tbl[14] = v(0, 1, 32'h100, 0, 0, 0, 32'h0, 0, 32'h14);
    tbl[15] = v(0, 0, 0, 0, 0, 1, 32'h100, 0, 32'h14);
    tbl[16] = v(0, 0, 0, 0, 0, 1, 32'h104, 1, 32'h100);
    tbl[17] = v(0, 0, 0, 0, 0, 1, 32'h108, 1, 32'h104);
    tbl[18] = v(0, 1, 32'h200, 1, 32'h80, 0, 32'h0, 0, 32'h104);
    tbl[19] = v(0, 0, 0, 0, 0, 1, 32'h80, 0, 32'h104);
    tbl[20] = v(0, 0, 0, 0, 0, 1, 32'h84, 1, 32'h80);
    tbl[21] = v(0, 1, 32'h103, 0, 0, 0, 32'h0, 0, 32'h80);
    tbl[22] = v(0, 0, 0, 0, 0, 1, 32'h100, 0, 32'h80);
    tbl[23] = v(0, 0, 0, 0, 0, 1, 32'h104, 1, 32'h100);
    tbl[24] = v(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 32'h0, 0, 32'h100);
    tbl[25] = v(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h100);
    tbl[26] = v(0, 0, 0, 0, 0, 1, 32'h0, 1, 32'hFFFF_FFFC);
    tbl[27] = v(0, 0, 0, 0, 0, 1, 32'h4, 1, 32'h0);
    tbl[28] = v(0, 0, 0, 0, 0, 1, 32'h8, 1, 32'h4);

    do_reset();
    for (int i = 0; i < NV; i++) begin
      step(tbl[i].stall, tbl[i].pcsrc, tbl[i].bt, tbl[i].trap, tbl[i].tp, 1'b1);
      check($sformatf("vec%0d_req", i), 32'(s_req), 32'(tbl[i].e_req));
      if (tbl[i].e_req) check($sformatf("vec%0d_addr", i), s_addr, tbl[i].e_addr);
      check($sformatf("vec%0d_valid", i), 32'(s_valid), 32'(tbl[i].e_valid));
      check($sformatf("vec%0d_pcf", i), s_pcf, tbl[i].e_pcf);
      check($sformatf("vec%0d_inst", i), s_inst,
            tbl[i].e_valid ? memword(tbl[i].e_pcf) : NOP_INSTR);
    end

    redirect_test("flush", 1'b1, 32'h100, 1'b0, 32'h0, 32'h100);
    redirect_test("trap_prio", 1'b1, 32'h200, 1'b1, 32'h80, 32'h80);

    // Backpressure: grant withheld cycles 2..5, responses 3 cycles after grant
    do_reset();
    rsp_lat = 3; rsp_en = 1'b1; cons0 = consumed;
    for (int c = 0; c < 30; c++) begin
      step(0, 0, 0, 0, 0, !((c >= 2) && (c <= 5)));
      if ((c >= 2) && (c <= 5)) begin
        check("bp_req_hold", 32'(s_req), 32'h1);
        check("bp_addr_hold", s_addr, 32'h4);
      end
      if (c == 4) begin
        check("bp_first_valid", 32'(s_valid), 32'h1);
        check("bp_first_pcf", s_pcf, 32'h0);
      end
      if ((c >= 5) && (c <= 8)) check("bp_gap_valid", 32'(s_valid), 32'h0);
      if (c == 9) begin
        check("bp_second_valid", 32'(s_valid), 32'h1);
        check("bp_second_pcf", s_pcf, 32'h4);
      end
    end
    check("bp_progress", 32'(consumed - cons0 >= 5), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
